mem_port_arbiter: RTL and testbench

// - Shares the single byte-wide RAM port between instruction fetch (IF) and load/store (MEM).
// - Each 1/2/4-byte access is split into sequential byte transfers, and the bytes are reassembled.
// - Drives stall_if_out/stall_mem_out into the pipeline stall combiner.
// - Sits between the IF and MEM stages and the top-level RAM pins.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - byte-wide RAM port arbiter for IF/MEM, optional MEM_PORT_ARB_RR_EN round-robin
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [31:0]       if_data_out,
  output logic              if_done_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_width_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  output logic [31:0]       mem_rdata_out,
  output logic              mem_done_out,
  output logic              stall_if_out,
  output logic              stall_mem_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Read data for the address driven in step s arrives in step s+LAT.
  localparam logic [2:0] LAT = 3'(RD_LAT);

  logic [1:0]        r_state;
  logic [2:0]        r_step;
  logic [2:0]        r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic              r_gnt_mem;
  logic [ADDR_W-1:0] r_ram_a;
  logic [7:0]        r_ram_dout;
  logic              r_ram_wr;
  logic [31:0]       r_if_data;
  logic [31:0]       r_mem_rdata;
  logic              r_if_done;
  logic              r_mem_done;
`ifdef MEM_PORT_ARB_RR_EN
  logic              r_last_mem;
`endif

  logic              w_grant;
  logic              w_pick_mem;
  logic              w_we;
  logic [2:0]        w_len;
  logic [ADDR_W-1:0] w_gaddr;
  logic [2:0]        w_step_inc;
  logic              w_cap;
  logic [1:0]        w_cap_idx;
  logic              w_last_rd;
  logic              w_last_wr;
  logic              w_more;
  logic [ADDR_W-1:0] w_a_next;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_buf_next;

  assign w_grant = if_req_in | mem_req_in;
`ifdef MEM_PORT_ARB_RR_EN
  // On a tie the requester not served last wins.
  assign w_pick_mem = mem_req_in & (~if_req_in | ~r_last_mem);
`else
  assign w_pick_mem = mem_req_in;
`endif
  assign w_we    = w_pick_mem & mem_we_in;
  assign w_gaddr = w_pick_mem ? mem_addr_in : if_addr_in;

  // Transfer length in bytes for the requester being granted.
  always_comb begin
    w_len = 3'd4;
    if (w_pick_mem) begin
      case (mem_width_in)
        2'b00:   w_len = 3'd1;
        2'b01:   w_len = 3'd2;
        default: w_len = 3'd4;
      endcase
    end
  end

  assign w_step_inc = r_step + 3'd1;
  assign w_cap      = (r_step >= LAT);
  assign w_cap_idx  = 2'(r_step - LAT);
  assign w_last_rd  = (r_step == r_len + LAT - 3'd1);
  assign w_last_wr  = (r_step == r_len - 3'd1);
  assign w_more     = (w_step_inc < r_len);
  assign w_a_next   = r_addr + ADDR_W'(w_step_inc);
  assign w_wbyte    = r_wdata[{w_step_inc[1:0], 3'b000} +: 8];

  // Merge the byte returning from RAM into the reassembly buffer.
  always_comb begin
    w_buf_next = r_buf;
    if (w_cap) begin
      w_buf_next[{w_cap_idx, 3'b000} +: 8] = ram_din_in;
    end
  end

  // Main sequencer; rdy_in low acts as a clock enable for all state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_step      <= 3'd0;
      r_len       <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_gnt_mem   <= 1'b0;
      r_ram_a     <= '0;
      r_ram_dout  <= 8'd0;
      r_ram_wr    <= 1'b0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
      r_last_mem  <= 1'b1;
`endif
    end else if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt_mem <= w_pick_mem;
            r_len     <= w_len;
            r_addr    <= w_gaddr;
            r_wdata   <= mem_wdata_in;
            r_step    <= 3'd0;
            r_buf     <= 32'd0;
            r_ram_a   <= w_gaddr;
`ifdef MEM_PORT_ARB_RR_EN
            r_last_mem <= w_pick_mem;
`endif
            if (w_we) begin
              r_ram_dout <= mem_wdata_in[7:0];
              r_ram_wr   <= 1'b1;
              r_state    <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_step <= w_step_inc;
          r_buf  <= w_buf_next;
          if (w_more) begin
            r_ram_a <= w_a_next;
          end
          if (w_last_rd) begin
            r_state <= S_DONE;
            if (r_gnt_mem) begin
              r_mem_rdata <= w_buf_next;
              r_mem_done  <= 1'b1;
            end else begin
              r_if_data <= w_buf_next;
              r_if_done <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_step <= w_step_inc;
          if (w_last_wr) begin
            r_ram_wr   <= 1'b0;
            r_state    <= S_DONE;
            r_mem_done <= 1'b1;
          end else begin
            r_ram_a    <= w_a_next;
            r_ram_dout <= w_wbyte;
          end
        end
        default: begin
          r_if_done  <= 1'b0;
          r_mem_done <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_a_out     = r_ram_a;
  assign ram_dout_out  = r_ram_dout;
  assign ram_wr_out    = r_ram_wr & rdy_in;
  assign if_data_out   = r_if_data;
  assign if_done_out   = r_if_done;
  assign mem_rdata_out = r_mem_rdata;
  assign mem_done_out  = r_mem_done;
  assign stall_if_out  = if_req_in & ~r_if_done;
  assign stall_mem_out = mem_req_in & ~r_mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    bit          rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_width = 2'b00;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall_if;
  logic        stall_mem;
  logic [7:0]  ram_din = 8'd0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  bit [7:0] ram [65536];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t if_q[$];
  exp_t mem_q[$];
  exp_t wr_q[$];
  exp_t ra_q[$];

  mem_port_arbiter #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .if_req_in(if_req), .if_addr_in(if_addr), .if_data_out(if_data), .if_done_out(if_done),
    .mem_req_in(mem_req), .mem_we_in(mem_we), .mem_width_in(mem_width), .mem_addr_in(mem_addr),
    .mem_wdata_in(mem_wdata), .mem_rdata_out(mem_rdata), .mem_done_out(mem_done),
    .stall_if_out(stall_if), .stall_mem_out(stall_mem),
    .ram_din_in(ram_din), .ram_dout_out(ram_dout), .ram_a_out(ram_a), .ram_wr_out(ram_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM shares the rdy domain: it holds its read byte while frozen.
  always @(posedge clk) begin
    if (cyc == 0) begin
      ram[16'h1000] <= 8'h13; ram[16'h1001] <= 8'h00;
      ram[16'h1002] <= 8'h50; ram[16'h1003] <= 8'h00;
      ram[16'h0005] <= 8'h80;
      ram[16'hFFFE] <= 8'h11; ram[16'hFFFF] <= 8'h22;
      ram[16'h0000] <= 8'h33; ram[16'h0001] <= 8'h44;
    end else if (rdy) begin
      if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
      ram_din <= ram[ram_a[15:0]];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents done pulses or writes.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (if_done) begin
        if (if_q.size() == 0) chk("if_done_unexpected", 32'd1, 32'd0);
        else begin
          e = if_q.pop_front();
          chk("if_done_cycle", cyc, e.cyc);
          chk("if_data", if_data, e.d);
          chk("if_stall_at_done", {31'd0, stall_if}, 32'd0);
        end
      end
      if (mem_done) begin
        if (mem_q.size() == 0) chk("mem_done_unexpected", 32'd1, 32'd0);
        else begin
          e = mem_q.pop_front();
          chk("mem_done_cycle", cyc, e.cyc);
          if (e.rd) chk("mem_rdata", mem_rdata, e.d);
          chk("mem_stall_at_done", {31'd0, stall_mem}, 32'd0);
        end
      end
      if (ram_wr) begin
        if (wr_q.size() == 0) chk("ram_wr_unexpected", ram_a, 32'hFFFF_FFFF);
        else begin
          e = wr_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", ram_a, e.a);
          chk("wr_byte", {24'd0, ram_dout}, e.d);
        end
      end
      for (int i = ra_q.size() - 1; i >= 0; i--) begin
        if (ra_q[i].cyc == cyc) begin
          chk("rd_addr", ram_a, ra_q[i].a);
          ra_q.delete(i);
        end
      end
    end
  end

  task automatic run_req(input bit is_if, input bit we, input logic [1:0] w,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_d, input int lat, input bit chk_a,
                         input int wr_off);
    int n;
    int g;
    bit seen;
    exp_t e;
    @(negedge clk);
    n = is_if ? 4 : (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    g = cyc;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_width = w; mem_addr = addr; mem_wdata = wdata;
    end
    e.cyc = g + lat; e.a = 32'd0; e.d = exp_d; e.rd = !we;
    if (is_if) if_q.push_back(e); else mem_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.a = addr + 32'(i);
      e.rd = 1'b0;
      if (we) begin
        e.cyc = g + wr_off + i; e.d = (wdata >> (8 * i)) & 32'hFF;
        wr_q.push_back(e);
      end else if (chk_a) begin
        e.cyc = g + lat - n - 1 + i;
        ra_q.push_back(e);
      end
    end
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      seen = is_if ? if_done : mem_done;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", is_if ? "if" : "mem");
    end
    if (is_if) if_req = 1'b0; else mem_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_a"}, ram_a, 32'd0);
    chk({tag, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
    chk({tag, "_ram_wr"}, {31'd0, ram_wr}, 32'd0);
    chk({tag, "_if_data"}, if_data, 32'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    chk({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
    chk({tag, "_mem_done"}, {31'd0, mem_done}, 32'd0);
  endtask

  initial begin
    int g;
    exp_t e;
    int lat_if_tie;
    int lat_mem_tie;
`ifdef MEM_PORT_ARB_RR_EN
    lat_if_tie = 6; lat_mem_tie = 10;
`else
    lat_if_tie = 10; lat_mem_tie = 3;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Simultaneous requests straight out of reset.
    fork
      run_req(1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'd0, 32'h0050_0013, lat_if_tie, 1'b1, 1);
      run_req(1'b0, 1'b0, 2'b00, 32'h0000_0005, 32'd0, 32'h0000_0080, lat_mem_tie, 1'b1, 1);
    join

    run_req(1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'd0, 32'h0050_0013, 6, 1'b1, 1);
    run_req(1'b0, 1'b1, 2'b10, 32'h0000_2002, 32'hAABB_CCDD, 32'd0, 5, 1'b0, 1);
    run_req(1'b0, 1'b0, 2'b00, 32'h0000_0005, 32'd0, 32'h0000_0080, 3, 1'b1, 1);
    run_req(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'd0, 32'h4433_2211, 6, 1'b1, 1);

    // Read frozen for three cycles mid-transfer.
    fork
      run_req(1'b0, 1'b0, 2'b11, 32'h0000_2002, 32'd0, 32'hAABB_CCDD, 9, 1'b0, 1);
      begin
        @(negedge clk);
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
      end
    join

    // Write frozen in its first byte cycle: no strobe then, bytes slip by one.
    fork
      run_req(1'b0, 1'b1, 2'b01, 32'h0000_0030, 32'h0000_1234, 32'd0, 4, 1'b0, 2);
      begin
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        rdy = 1'b1;
      end
    join
    run_req(1'b0, 1'b0, 2'b01, 32'h0000_0030, 32'd0, 32'h0000_1234, 4, 1'b1, 1);

    // Reset during the third byte of a word store.
    @(negedge clk);
    g = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10;
    mem_addr = 32'h0000_0040; mem_wdata = 32'h1122_3344;
    e.rd = 1'b0;
    e.cyc = g + 1; e.a = 32'h40; e.d = 32'h44; wr_q.push_back(e);
    e.cyc = g + 2; e.a = 32'h41; e.d = 32'h33; wr_q.push_back(e);
    e.cyc = g + 3; e.a = 32'h42; e.d = 32'h22; wr_q.push_back(e);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    mem_req = 1'b0;
    #1;
    chk("ram_wr_on_reset", {31'd0, ram_wr}, 32'd0);
    repeat (2) @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;

    run_req(1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'd0, 32'h0000_3344, 6, 1'b1, 1);

    repeat (3) @(negedge clk);
    chk("if_q_drained", if_q.size(), 32'd0);
    chk("mem_q_drained", mem_q.size(), 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("ra_q_drained", ra_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
